// File: rtl/clk_gate_ctrl_pkg.sv
// rtl/clk_gate_ctrl_pkg.sv - shared types and constants for the clock-gate enable generator
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    CGC_ACTIVE = 2'd0,
    CGC_GATED  = 2'd1,
    CGC_WAKE   = 2'd2
  } cgc_state_e;

  localparam int CGC_STATS_W = 32;

endpackage

// File: rtl/cgc_down_cnt.sv
// rtl/cgc_down_cnt.sv - loadable down-counter with an ==1 flag, holds at zero
module cgc_down_cnt #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_one
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_one = (r_cnt == W'(1));

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - idle-driven clock-gate enable with wake-up ready masking
// Optional gated-cycle statistics counter: CLK_GATE_CTRL_STATS_EN
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   force_en_i,
  input  logic                   busy_i,
  input  logic                   in_valid_i,
  input  logic                   in_ready_i,
  output logic                   in_ready_o,
  output logic                   clk_en_o,
  output logic                   gated_o,
  input  logic                   stats_clr_i,
  output logic [CGC_STATS_W-1:0] gated_cycles_o
);

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES);
  localparam logic             NO_WAKE = (WAKE_CYCLES == 0);

  generate
    if (IDLE_CYCLES < 1) begin : g_bad_idle
      $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
  endgenerate

  cgc_state_e r_state;
  logic       r_clk_en;
  logic       r_gated;
  logic       w_activity;
  logic       w_wake_req;
  logic       w_icnt_load;
  logic       w_icnt_dec;
  logic       w_icnt_one;
  logic       w_wcnt_load;
  logic       w_wcnt_dec;
  logic       w_wcnt_one;

  assign w_activity  = in_valid_i | busy_i | force_en_i;
  assign w_wake_req  = (r_state == CGC_GATED) & w_activity;
  assign w_icnt_load = ((r_state == CGC_ACTIVE) & w_activity)
                     | (w_wake_req & NO_WAKE)
                     | ((r_state == CGC_WAKE) & w_wcnt_one);
  assign w_icnt_dec  = (r_state == CGC_ACTIVE) & ~w_activity;
  assign w_wcnt_load = w_wake_req & ~NO_WAKE;
  assign w_wcnt_dec  = (r_state == CGC_WAKE);

  cgc_down_cnt #(.W(CNT_W), .RST_VAL(IDLE_LD)) u_icnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_icnt_load),
    .i_load_val (IDLE_LD),
    .i_dec      (w_icnt_dec),
    .o_one      (w_icnt_one)
  );

  cgc_down_cnt #(.W(CNT_W), .RST_VAL('0)) u_wcnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_wcnt_load),
    .i_load_val (WAKE_LD),
    .i_dec      (w_wcnt_dec),
    .o_one      (w_wcnt_one)
  );

  // Enable and status are registered alongside the state so the gate cell never sees input glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= CGC_ACTIVE;
      r_clk_en <= 1'b1;
      r_gated  <= 1'b0;
    end else begin
      case (r_state)
        CGC_ACTIVE: begin
          if (!w_activity && w_icnt_one) begin
            r_state  <= CGC_GATED;
            r_clk_en <= 1'b0;
            r_gated  <= 1'b1;
          end
        end
        CGC_GATED: begin
          if (w_activity) begin
            r_state  <= NO_WAKE ? CGC_ACTIVE : CGC_WAKE;
            r_clk_en <= 1'b1;
            r_gated  <= 1'b0;
          end
        end
        CGC_WAKE: begin
          if (w_wcnt_one) begin
            r_state <= CGC_ACTIVE;
          end
        end
        default: begin
          r_state  <= CGC_ACTIVE;
          r_clk_en <= 1'b1;
          r_gated  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en_o   = r_clk_en;
  assign gated_o    = r_gated;
  assign in_ready_o = (r_state == CGC_ACTIVE) & in_ready_i;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [CGC_STATS_W-1:0] r_gated_cycles;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gated_cycles <= '0;
    end else if (stats_clr_i) begin
      r_gated_cycles <= '0;
    end else if (r_gated && (r_gated_cycles != '1)) begin
      r_gated_cycles <= r_gated_cycles + 1'b1;
    end
  end

  assign gated_cycles_o = r_gated_cycles;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr_i;
  assign gated_cycles_o     = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed scoreboard bench for clk_gate_ctrl (IDLE=4, WAKE=2 and WAKE=0)
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_en = 1'b0;
  logic        busy = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready_i = 1'b1;
  logic        stats_clr = 1'b0;
  logic        rdy0, en0, gated0;
  logic        rdy1, en1, gated1;
  logic [31:0] gc0, gc1;

  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  int          pend = 0;
  logic [31:0] model_gcnt = '0;

  typedef struct {
    logic        en;
    logic        gated;
    logic        rdy;
    logic [31:0] gcnt;
  } exp_t;

  exp_t exp_q[$];
  int   beat_q[$];

  always #5 clk = ~clk;

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .force_en_i     (force_en),
    .busy_i         (busy),
    .in_valid_i     (in_valid),
    .in_ready_i     (in_ready_i),
    .in_ready_o     (rdy0),
    .clk_en_o       (en0),
    .gated_o        (gated0),
    .stats_clr_i    (stats_clr),
    .gated_cycles_o (gc0)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(0)) u_dut_w0 (
    .clk_i          (clk),
    .rst_i          (rst),
    .force_en_i     (force_en),
    .busy_i         (busy),
    .in_valid_i     (in_valid),
    .in_ready_i     (in_ready_i),
    .in_ready_o     (rdy1),
    .clk_en_o       (en1),
    .gated_o        (gated1),
    .stats_clr_i    (stats_clr),
    .gated_cycles_o (gc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stats_exp();
`ifdef CLK_GATE_CTRL_STATS_EN
    return model_gcnt;
`else
    return 32'd0;
`endif
  endfunction

  // Present n beats; each is expected to be accepted at the given cycle offsets.
  task automatic send(input int n, input int first_ofs);
    for (int k = 0; k < n; k++) beat_q.push_back(cyc_no + first_ofs + k);
    pend += n;
    in_valid = 1'b1;
  endtask

  task automatic cyc(input logic e_en, input logic e_gated, input logic e_rdy, input string tag);
    exp_t e;
    int   want;
    e.en = e_en; e.gated = e_gated; e.rdy = e_rdy; e.gcnt = stats_exp();
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".clk_en"}, 32'(en0), 32'(e.en));
    chk({tag, ".gated"}, 32'(gated0), 32'(e.gated));
    chk({tag, ".in_ready"}, 32'(rdy0), 32'(e.rdy));
    chk({tag, ".gated_cycles"}, gc0, e.gcnt);
    if (in_valid && rdy0) begin
      want = (beat_q.size() > 0) ? beat_q.pop_front() : -1;
      chk({tag, ".beat_cycle"}, 32'(cyc_no), 32'(want));
      pend--;
    end
    if (e_gated) model_gcnt++;
    if (stats_clr) model_gcnt = '0;
    cyc_no++;
    @(posedge clk);
    #1;
    in_valid = (pend > 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.clk_en", 32'(en0), 32'd1);
    chk("rst.gated", 32'(gated0), 32'd0);
    chk("rst.in_ready", 32'(rdy0), 32'd1);
    chk("rst.gated_cycles", gc0, 32'd0);
    in_ready_i = 1'b0;
    #1;
    chk("rst.in_ready_follow", 32'(rdy0), 32'd0);
    in_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, "idle_run");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, "gated");
    chk("stats_after_10", gc0, stats_exp());
    stats_clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, "clr");
    stats_clr = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, "after_clr");

    // Wake on traffic: beats land only once ready passes through after two wake cycles.
    send(2, 3);
    chk("w0.gated_before", 32'(gated1), 32'd1);
    chk("w0.ready_before", 32'(rdy1), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, "wake_req");
    chk("w0.clk_en", 32'(en1), 32'd1);
    chk("w0.gated", 32'(gated1), 32'd0);
    chk("w0.ready_direct", 32'(rdy1), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, "wake1");
    cyc(1'b1, 1'b0, 1'b0, "wake2");
    cyc(1'b1, 1'b0, 1'b1, "beat0");
    cyc(1'b1, 1'b0, 1'b1, "beat1");
    chk("beats_left", 32'(beat_q.size()), 32'd0);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, "pre_busy");
    busy = 1'b1;
    in_ready_i = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, "busy");
    busy = 1'b0;
    in_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, "post_busy");
    cyc(1'b0, 1'b1, 1'b0, "regate");

    force_en = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, "force_req");
    cyc(1'b1, 1'b0, 1'b0, "force_wake1");
    cyc(1'b1, 1'b0, 1'b0, "force_wake2");
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b1, "force_hold");
    force_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, "idle2");
    cyc(1'b0, 1'b1, 1'b0, "gated2");
    busy = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, "wake_req2");
    busy = 1'b0;

    // Now in WAKE: reset must take effect without waiting for a clock edge.
    chk("wake.in_ready", 32'(rdy0), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.clk_en", 32'(en0), 32'd1);
    chk("arst.gated", 32'(gated0), 32'd0);
    chk("arst.in_ready", 32'(rdy0), 32'd1);
    chk("arst.gated_cycles", gc0, 32'd0);
    model_gcnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, "post_rst");
    cyc(1'b0, 1'b1, 1'b0, "post_rst_gate");
    cyc(1'b0, 1'b1, 1'b0, "post_rst_gate2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
